ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter that sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
//  Drives the open-drain clk/data lines through active-high pull-low enables; the board-level tristate sits outside.
//  Sits beside the keyboard receive path. While tx_busy=1, the receiver's output is not valid.
// PARAMETERS
//  INHIBIT_CYCLES  5000     sys_clk cycles that clock is held low before the request (100us @50MHz)
//  TIMEOUT_CYCLES  1000000  max sys_clk cycles from clock release to ack/idle (20ms @50MHz)
//  CNT_W           20       width of the shared cycle counter; must hold both values above
// PORTS
//  sys_clk      in   1  system clock
//  rst_n        in   1  async active-low reset
//  clk_ps2      in   1  PS/2 clock line as sensed (asynchronous)
//  data_ps2     in   1  PS/2 data line as sensed (asynchronous)
//  tx_start     in   1  1-cycle request; accepted only when tx_busy=0
//  tx_data      in   8  byte to send; captured on the accepted tx_start
//  tx_busy      out  1  transfer in progress
//  tx_done      out  1  1-cycle pulse: byte acknowledged by the device
//  tx_err       out  1  1-cycle pulse: no ack (data high at ack) or timeout
//  clk_ps2_oe   out  1  1 = pull clock line low
//  data_ps2_oe  out  1  1 = pull data line low
// BEHAVIOUR
//  Interface: one clock, sys_clk. Reset rst_n is asynchronous, active-low.
//  Reset values: all outputs 0, so both lines are released. Asserting rst_n mid-transfer releases the lines immediately.
//  Line inputs pass a 2-FF synchroniser. A falling edge (fe) is synced clock 1 -> 0, one cycle wide.
//  The shift register holds {stop=1, parity, tx_data[7:0]}. Parity is odd: ~^tx_data.
//  Transfers never overlap: tx_start while busy is ignored.
//  States:
//   IDLE: oe=0 on both lines.
//    On tx_start: capture the frame, busy=1, clear counter, go to INHIBIT.
//   INHIBIT: clk_oe=1.
//    When counter == INHIBIT_CYCLES-1: data_oe=1 (start bit) and go to REQ.
//   REQ: hold clk_oe=1 and data_oe=1 for exactly 1 more cycle.
//    Then clk_oe=0, clear counter, go to SEND with bit index 0.
//   SEND: on each fe, data_oe <= ~frame[idx] and idx++.
//    fe #1..#8 send data LSB first. fe #9 sends parity. fe #10 sends stop, which releases data.
//    After fe #10, go to ACK.
//   ACK: on the next fe, sample data.
//    data = 0: go to WAIT_IDLE.
//    data = 1: raise tx_err and go to IDLE.
//   WAIT_IDLE: wait until synced clock and data are both 1.
//    Then raise tx_done and go to IDLE. busy drops in the same cycle as the pulse.
//  Timeout: from REQ exit, the counter runs in SEND, ACK and WAIT_IDLE.
//   Reaching TIMEOUT_CYCLES-1 causes tx_err, release of both lines and return to IDLE.
//  tx_done and tx_err are never high together. Each is exactly 1 cycle.
//  tx_start coincident with a done/err cycle is ignored; the next cycle may start a transfer.
//  The counter saturates; it never wraps.
//  The data line changes only in the sys_clk cycle after fe, i.e. while the device clock is low.
// STRUCTURE
//  Shared include ps2_defs.vh: state encodings; command constants
//   PS2_CMD_LEDS=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA.
//  Sub-module ps2_line_sync: 2-FF sync of clk/data plus falling-edge pulse, reusable by the receive path.
//  The FSM, 10-bit shift register, 4-bit index and CNT_W counter live in this module.
// TESTING (bench uses INHIBIT_CYCLES=8, TIMEOUT_CYCLES=400, device model clock period 40 cycles)
//  1. Send 0xED -> clk_oe low 8 cycles, then data low.
//     Bits on fe 1..10 = 1,0,1,1,0,1,1,1,p=1,stop=1. Model acks -> tx_done 1 pulse, busy 0.
//  2. Send 0x07 -> parity bit 0. Send 0x00 -> parity bit 1. Both complete with tx_done.
//  3. Model drives no ack (data high at fe #11) -> tx_err 1 pulse, both oe 0, tx_done never set.
//  4. Model never clocks -> tx_err exactly 400 cycles after REQ exit, lines released.
//  5. tx_start with 0x55 while busy with 0xFF -> ignored. Frame on the wire is 0xFF; only one tx_done.
//  6. rst_n low during SEND bit 4 -> same-cycle oe=0 and busy=0. After release, a new send 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM state encodings,
// common keyboard command bytes and the frame builder.
package ps2_host_tx_pkg;

  // Transmit FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  // Frequently used host-to-keyboard command bytes and the device ack byte
  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  // Bits shifted out after the start bit: 8 data, parity, stop
  localparam int PS2_FRAME_W = 10;

  // Build {stop, odd parity, data}; bit 0 goes out first
  function automatic logic [PS2_FRAME_W-1:0] ps2_make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a one-cycle
// falling-edge strobe on the synchronised clock. Idle lines read as 1, so the
// flops reset to 1 to avoid a spurious edge when reset is released.
module ps2_line_sync (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic i_line_clk,
  input  logic i_line_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fe
);

  // bit 0 = clock line, bit 1 = data line
  logic [1:0] r_meta;
  logic [1:0] r_sync;
  logic       r_clk_prev;

  // Metastability stages and previous synced clock for edge detection
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta     <= 2'b11;
      r_sync     <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_meta     <= {i_line_data, i_line_clk};
      r_sync     <= r_meta;
      r_clk_prev <= r_sync[0];
    end
  end

  assign o_clk_sync  = r_sync[0];
  assign o_data_sync = r_sync[1];
  assign o_clk_fe    = r_clk_prev & ~r_sync[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Inhibits the bus, issues the request-to-send,
// shifts out data/parity/stop on device clock falling edges, checks the device
// ack and waits for the bus to go idle. A single frame-wide watchdog covers the
// whole device-clocked part of the transfer. Line drivers are active-high
// pull-low enables for an external open-drain buffer.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       clk_ps2,
  input  logic       data_ps2,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  output logic       clk_ps2_oe,
  output logic       data_ps2_oe
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       IDX_LAST     = 4'(PS2_FRAME_W - 1);

  ps2_tx_state_t          r_state;
  logic [PS2_FRAME_W-1:0] r_frame;
  logic [3:0]             r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_tx_done;
  logic                   r_tx_err;
  logic                   r_clk_oe;
  logic                   r_data_oe;

  logic                   w_clk_sync;
  logic                   w_data_sync;
  logic                   w_fe;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_timeout;
  logic                   w_start_ok;

  ps2_line_sync u_line_sync (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .i_line_clk  (clk_ps2),
    .i_line_data (data_ps2),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fe    (w_fe)
  );

  // Saturating increment so a stuck transfer never wraps back under the limit
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
  assign w_timeout  = (r_cnt == TIMEOUT_LAST);
  // A start landing on the done/err cycle belongs to the old transfer's handshake
  assign w_start_ok = tx_start & ~r_tx_done & ~r_tx_err;

  // Transmit FSM with registered line enables and status pulses
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_frame   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      r_tx_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          if (w_start_ok) begin
            r_frame  <= ps2_make_frame(tx_data);
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_clk_oe <= 1'b1;
            r_state  <= ST_INHIBIT;
          end
        end

        ST_INHIBIT: begin
          r_cnt <= w_cnt_inc;
          if (r_cnt == INHIBIT_LAST) begin
            // Start bit goes on the wire while clock is still held low
            r_data_oe <= 1'b1;
            r_state   <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Hand the clock to the device; data stays low as the start bit
          r_clk_oe <= 1'b0;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_state  <= ST_SEND;
        end

        ST_SEND: begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_tx_err  <= 1'b1;
            r_busy    <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_fe) begin
            // Changing data right after the falling edge keeps it stable for
            // the device's sample on the following rising edge
            r_data_oe <= ~r_frame[r_idx];
            r_idx     <= r_idx + 4'd1;
            if (r_idx == IDX_LAST) begin
              r_state <= ST_ACK;
            end
          end
        end

        ST_ACK: begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_tx_err  <= 1'b1;
            r_busy    <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_fe) begin
            if (!w_data_sync) begin
              r_state <= ST_WAIT_IDLE;
            end else begin
              r_tx_err <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          r_cnt <= w_cnt_inc;
          if (w_timeout) begin
            r_tx_err  <= 1'b1;
            r_busy    <= 1'b0;
            r_data_oe <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_clk_sync && w_data_sync) begin
            r_tx_done <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end

        default: begin
          r_clk_oe  <= 1'b0;
          r_data_oe <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy     = r_busy;
  assign tx_done     = r_tx_done;
  assign tx_err      = r_tx_err;
  assign clk_ps2_oe  = r_clk_oe;
  assign data_ps2_oe = r_data_oe;

endmodule
